// File: rtl/flush_ctrl.sv
// Flush sequencer/arbiter: fixed-priority pick of pending flush sources, one-hot stage walk,
// drain-ack wait with timeout, then a single redirect pulse to fetch.
module flush_ctrl #(
    parameter int unsigned NUM_SRC     = 4,
    parameter int unsigned NUM_STG     = 5,
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned ACK_TIMEOUT = 15
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [NUM_SRC-1:0]        flush_req,
    input  logic [NUM_SRC*ADDR_W-1:0] flush_pc,
    input  logic                      flush_ack,
    output logic [NUM_SRC-1:0]        flush_grant,
    output logic [NUM_STG-1:0]        flush_stage,
    output logic                      stall_fetch,
    output logic                      redirect_valid,
    output logic [ADDR_W-1:0]         redirect_pc,
    output logic                      busy,
    output logic                      ack_timeout_err
);

    localparam int unsigned SrcW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
    localparam int unsigned CntW = (NUM_STG > 1) ? $clog2(NUM_STG) : 1;
    localparam logic [CntW-1:0] LastStg    = CntW'(NUM_STG - 1);
    localparam logic [7:0]      TimeoutCnt = 8'(ACK_TIMEOUT);

    localparam logic [1:0] StIdle     = 2'd0;
    localparam logic [1:0] StFlush    = 2'd1;
    localparam logic [1:0] StWaitAck  = 2'd2;
    localparam logic [1:0] StRedirect = 2'd3;

    logic [1:0]                     state_q, state_d;
    logic [NUM_SRC-1:0]             pending_q, pending_d;
    logic [NUM_SRC-1:0][ADDR_W-1:0] pc_q, pc_d;
    logic [CntW-1:0]                cnt_q, cnt_d;
    logic [7:0]                     wait_q, wait_d;
    logic [NUM_SRC-1:0]             grant_q, grant_d;
    logic [NUM_STG-1:0]             stage_q, stage_d;
    logic                           rv_q, rv_d;
    logic [ADDR_W-1:0]              rpc_q, rpc_d;
    logic                           busy_q, busy_d;
    logic                           err_q, err_d;

    logic [SrcW-1:0]    win_idx;
    logic               any_pend;
    logic [NUM_SRC-1:0] clr;

    // Scan downward so the lowest set index is the last one written.
    always_comb begin
        win_idx  = '0;
        any_pend = |pending_q;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (pending_q[i]) begin
                win_idx = SrcW'(i);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wait_d  = wait_q;
        grant_d = '0;
        stage_d = '0;
        rv_d    = 1'b0;
        rpc_d   = rpc_q;
        busy_d  = busy_q;
        err_d   = err_q;
        clr     = '0;
        case (state_q)
            StIdle: begin
                if (any_pend) begin
                    grant_d[win_idx] = 1'b1;
                    clr[win_idx]     = 1'b1;
                    rpc_d            = pc_q[win_idx];
                    cnt_d            = '0;
                    busy_d           = 1'b1;
                    state_d          = StFlush;
                end
            end
            StFlush: begin
                stage_d[cnt_q] = 1'b1;
                if (cnt_q == LastStg) begin
                    wait_d  = '0;
                    state_d = StWaitAck;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StWaitAck: begin
                if (flush_ack) begin
                    rv_d    = 1'b1;
                    state_d = StRedirect;
                end else if (wait_q == TimeoutCnt) begin
                    rv_d    = 1'b1;
                    err_d   = 1'b1;
                    state_d = StRedirect;
                end else begin
                    wait_d = wait_q + 8'd1;
                end
            end
            StRedirect: begin
                busy_d  = 1'b0;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // A new request on the granting edge keeps its pending bit (set beats clear).
    always_comb begin
        pending_d = (pending_q & ~clr) | flush_req;
        for (int i = 0; i < NUM_SRC; i++) begin
            pc_d[i] = flush_req[i] ? flush_pc[i*ADDR_W +: ADDR_W] : pc_q[i];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= StIdle;
            pending_q <= '0;
            pc_q      <= '0;
            cnt_q     <= '0;
            wait_q    <= '0;
            grant_q   <= '0;
            stage_q   <= '0;
            rv_q      <= 1'b0;
            rpc_q     <= '0;
            busy_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            pc_q      <= pc_d;
            cnt_q     <= cnt_d;
            wait_q    <= wait_d;
            grant_q   <= grant_d;
            stage_q   <= stage_d;
            rv_q      <= rv_d;
            rpc_q     <= rpc_d;
            busy_q    <= busy_d;
            err_q     <= err_d;
        end
    end

    assign flush_grant     = grant_q;
    assign flush_stage     = stage_q;
    assign stall_fetch     = busy_q;
    assign redirect_valid  = rv_q;
    assign redirect_pc     = rpc_q;
    assign busy            = busy_q;
    assign ack_timeout_err = err_q;

endmodule

// File: tb/tb_flush_ctrl.sv
// Bench for flush_ctrl: timeline-based reference model checked every cycle, directed scenarios
// with literal expectations, then randomized traffic with varying ack behaviour.
module tb_flush_ctrl;

    localparam int NUM_SRC     = 4;
    localparam int NUM_STG     = 5;
    localparam int ADDR_W      = 32;
    localparam int ACK_TIMEOUT = 15;

    logic                      clk = 1'b0;
    logic                      reset_n;
    logic [NUM_SRC-1:0]        flush_req;
    logic [NUM_SRC*ADDR_W-1:0] flush_pc;
    logic                      flush_ack;
    logic [NUM_SRC-1:0]        flush_grant;
    logic [NUM_STG-1:0]        flush_stage;
    logic                      stall_fetch;
    logic                      redirect_valid;
    logic [ADDR_W-1:0]         redirect_pc;
    logic                      busy;
    logic                      ack_timeout_err;

    flush_ctrl #(
        .NUM_SRC    (NUM_SRC),
        .NUM_STG    (NUM_STG),
        .ADDR_W     (ADDR_W),
        .ACK_TIMEOUT(ACK_TIMEOUT)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .flush_req      (flush_req),
        .flush_pc       (flush_pc),
        .flush_ack      (flush_ack),
        .flush_grant    (flush_grant),
        .flush_stage    (flush_stage),
        .stall_fetch    (stall_fetch),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .busy           (busy),
        .ack_timeout_err(ack_timeout_err)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    function automatic void chk(input string name, input logic [63:0] act,
                                input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    function automatic int lowest_set(input logic [NUM_SRC-1:0] p);
        for (int i = 0; i < NUM_SRC; i++) begin
            if (p[i]) return i;
        end
        return -1;
    endfunction

    // Reference model: a flush is a timeline measured in cycles since its grant.
    logic [NUM_SRC-1:0] m_pend   = '0;
    logic [ADDR_W-1:0]  m_pcr [NUM_SRC];
    logic               m_active = 1'b0;
    logic               m_redir  = 1'b0;
    int                 m_age    = 0;
    logic               m_err    = 1'b0;
    logic [NUM_SRC-1:0] e_grant  = '0;
    logic [NUM_STG-1:0] e_stage  = '0;
    logic               e_rv     = 1'b0;
    logic [ADDR_W-1:0]  e_rpc    = '0;
    logic               e_busy   = 1'b0;
    logic [NUM_SRC-1:0] m_clr;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_pend = '0;
            for (int i = 0; i < NUM_SRC; i++) m_pcr[i] = '0;
            m_active = 1'b0;
            m_redir  = 1'b0;
            m_age    = 0;
            m_err    = 1'b0;
            e_grant  = '0;
            e_stage  = '0;
            e_rv     = 1'b0;
            e_rpc    = '0;
            e_busy   = 1'b0;
        end else begin
            m_clr   = '0;
            e_grant = '0;
            e_stage = '0;
            e_rv    = 1'b0;
            if (!m_active) begin
                if (m_pend != '0) begin
                    int w;
                    w          = lowest_set(m_pend);
                    e_grant[w] = 1'b1;
                    m_clr[w]   = 1'b1;
                    e_rpc      = m_pcr[w];
                    m_active   = 1'b1;
                    m_redir    = 1'b0;
                    m_age      = 0;
                end
            end else if (m_redir) begin
                m_active = 1'b0;
                m_redir  = 1'b0;
            end else if (m_age < NUM_STG) begin
                m_age++;
                e_stage[m_age-1] = 1'b1;
            end else begin
                if (flush_ack || (m_age - NUM_STG) == ACK_TIMEOUT) begin
                    e_rv    = 1'b1;
                    m_redir = 1'b1;
                    if (!flush_ack) m_err = 1'b1;
                end else begin
                    m_age++;
                end
            end
            e_busy = m_active;
            m_pend = (m_pend & ~m_clr) | flush_req;
            for (int i = 0; i < NUM_SRC; i++) begin
                if (flush_req[i]) m_pcr[i] = flush_pc[i*ADDR_W +: ADDR_W];
            end
        end
    end

    always @(negedge clk) begin
        chk("grant", 64'(flush_grant), 64'(e_grant));
        chk("stage", 64'(flush_stage), 64'(e_stage));
        chk("redirect_valid", 64'(redirect_valid), 64'(e_rv));
        chk("redirect_pc", 64'(redirect_pc), 64'(e_rpc));
        chk("busy", 64'(busy), 64'(e_busy));
        chk("stall_fetch", 64'(stall_fetch), 64'(e_busy));
        chk("ack_timeout_err", 64'(ack_timeout_err), 64'(m_err));
    end

    logic [NUM_SRC-1:0] lg    [64];
    logic [NUM_STG-1:0] ls    [64];
    logic               lrv   [64];
    logic [ADDR_W-1:0]  lpc   [64];
    logic               lbusy [64];
    logic               lstall[64];
    logic               lerr  [64];

    task automatic step(input int k);
        @(negedge clk);
        lg[k]     = flush_grant;
        ls[k]     = flush_stage;
        lrv[k]    = redirect_valid;
        lpc[k]    = redirect_pc;
        lbusy[k]  = busy;
        lstall[k] = stall_fetch;
        lerr[k]   = ack_timeout_err;
        @(posedge clk);
        #2;
    endtask

    task automatic drive_req(input int src, input logic [ADDR_W-1:0] pc);
        flush_req[src]                 = 1'b1;
        flush_pc[src*ADDR_W +: ADDR_W] = pc;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, expected $finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int nrv;
        int ng;
        reset_n   = 1'b0;
        flush_req = '0;
        flush_pc  = '0;
        flush_ack = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        reset_n = 1'b1;

        @(negedge clk);
        chk("rst_grant", 64'(flush_grant), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_pc", 64'(redirect_pc), 64'd0);
        @(posedge clk);
        #2;

        // Single request, ack already high.
        flush_ack = 1'b1;
        drive_req(2, 32'h0000_1000);
        for (int k = 0; k < 12; k++) begin
            if (k == 1) flush_req = '0;
            step(k);
        end
        chk("t1_grant_early", 64'(lg[1]), 64'd0);
        chk("t1_grant", 64'(lg[2]), 64'b0100);
        for (int i = 0; i < NUM_STG; i++) chk("t1_stage", 64'(ls[3+i]), 64'(1) << i);
        chk("t1_rv_early", 64'(lrv[7]), 64'd0);
        chk("t1_rv", 64'(lrv[8]), 64'd1);
        chk("t1_pc", 64'(lpc[8]), 64'h1000);
        chk("t1_stall_before", 64'(lstall[1]), 64'd0);
        chk("t1_stall_first", 64'(lstall[2]), 64'd1);
        chk("t1_stall_last", 64'(lstall[8]), 64'd1);
        chk("t1_stall_after", 64'(lstall[9]), 64'd0);

        // Simultaneous requests from sources 1 and 3.
        drive_req(1, 32'hAAAA_0010);
        drive_req(3, 32'h3333_0300);
        for (int k = 0; k < 20; k++) begin
            if (k == 1) flush_req = '0;
            step(k);
        end
        chk("t2_grant_a", 64'(lg[2]), 64'b0010);
        chk("t2_rv_a", 64'(lrv[8]), 64'd1);
        chk("t2_pc_a", 64'(lpc[8]), 64'hAAAA_0010);
        chk("t2_idle_gap", 64'(lbusy[9]), 64'd0);
        chk("t2_grant_b", 64'(lg[10]), 64'b1000);
        chk("t2_rv_b", 64'(lrv[16]), 64'd1);
        chk("t2_pc_b", 64'(lpc[16]), 64'h3333_0300);

        // Higher-priority request while a flush is running.
        drive_req(2, 32'h0000_2200);
        for (int k = 0; k < 20; k++) begin
            if (k == 1) flush_req = '0;
            if (k == 4) drive_req(0, 32'h0000_0040);
            if (k == 5) flush_req = '0;
            step(k);
        end
        chk("t3_grant_2", 64'(lg[2]), 64'b0100);
        for (int i = 0; i < NUM_STG; i++) chk("t3_stage", 64'(ls[3+i]), 64'(1) << i);
        chk("t3_rv_2", 64'(lrv[8]), 64'd1);
        chk("t3_pc_2", 64'(lpc[8]), 64'h2200);
        chk("t3_grant_0", 64'(lg[10]), 64'b0001);
        chk("t3_rv_0", 64'(lrv[16]), 64'd1);
        chk("t3_pc_0", 64'(lpc[16]), 64'h40);

        // Missing ack: WAIT_ACK entered in cycle 7, redirect ACK_TIMEOUT+1 later.
        flush_ack = 1'b0;
        drive_req(1, 32'h0000_5000);
        for (int k = 0; k < 30; k++) begin
            if (k == 1) flush_req = '0;
            step(k);
        end
        chk("t4_last_stage", 64'(ls[7]), 64'b10000);
        chk("t4_rv_early", 64'(lrv[22]), 64'd0);
        chk("t4_rv", 64'(lrv[23]), 64'd1);
        chk("t4_err_early", 64'(lerr[22]), 64'd0);
        chk("t4_err", 64'(lerr[23]), 64'd1);
        chk("t4_err_sticky", 64'(lerr[29]), 64'd1);
        chk("t4_pc", 64'(lpc[23]), 64'h5000);
        flush_ack = 1'b1;

        // Reset mid-flush with another source pending.
        drive_req(2, 32'h0000_7700);
        for (int k = 0; k < 5; k++) begin
            if (k == 1) flush_req = '0;
            if (k == 3) drive_req(0, 32'h0000_0990);
            if (k == 4) flush_req = '0;
            step(k);
        end
        @(negedge clk);
        chk("t5_stage_pre", 64'(flush_stage), 64'b00100);
        #1;
        reset_n = 1'b0;
        #1;
        chk("t5_rst_stage", 64'(flush_stage), 64'd0);
        chk("t5_rst_busy", 64'(busy), 64'd0);
        chk("t5_rst_stall", 64'(stall_fetch), 64'd0);
        chk("t5_rst_err", 64'(ack_timeout_err), 64'd0);
        chk("t5_rst_pc", 64'(redirect_pc), 64'd0);
        @(posedge clk);
        @(posedge clk);
        #2;
        reset_n = 1'b1;
        nrv = 0;
        ng  = 0;
        for (int k = 0; k < 12; k++) begin
            step(k);
            if (lrv[k]) nrv++;
            if (lg[k] != '0) ng++;
        end
        chk("t5_no_redirect", 64'(nrv), 64'd0);
        chk("t5_no_grant", 64'(ng), 64'd0);
        drive_req(3, 32'h0000_8800);
        for (int k = 0; k < 12; k++) begin
            if (k == 1) flush_req = '0;
            step(k);
        end
        chk("t5_grant", 64'(lg[2]), 64'b1000);
        chk("t5_rv", 64'(lrv[8]), 64'd1);
        chk("t5_pc", 64'(lpc[8]), 64'h8800);

        // Randomized traffic: frequent acks first, then mostly missing acks.
        for (int c = 0; c < 2500; c++) begin
            int ack_pct;
            ack_pct = (c < 1200) ? 60 : 3;
            for (int i = 0; i < NUM_SRC; i++) begin
                flush_req[i]               = ($urandom_range(0, 99) < 6);
                flush_pc[i*ADDR_W +: ADDR_W] = $urandom;
            end
            flush_ack = ($urandom_range(0, 99) < ack_pct);
            if (c == 1800) reset_n = 1'b0;
            if (c == 1802) reset_n = 1'b1;
            @(posedge clk);
            #2;
        end
        flush_req = '0;
        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/flush_ctrl.md
# flush_ctrl

Flush sequencer and arbiter for the pipeline flush path. Collects flush requests from several sources (branch resolve, exception, interrupt, debug), selects one by fixed priority, drives a staged one-hot flush pulse through each pipeline stage one cycle apart, waits for downstream drain acknowledge, then issues a single redirect to fetch. Sits between the requesting units and the per-stage flush inputs.

## Interface
- NUM_SRC, 4: number of flush requesters; index 0 is highest priority.
- NUM_STG, 5: number of pipeline stages to flush; stage 0 is the front (fetch).
- ADDR_W, 32: redirect address width.
- ACK_TIMEOUT, 15: maximum cycles spent in WAIT_ACK; range 1..255.
- clk  in  1  clock; all state updates on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- flush_req  in  NUM_SRC  per-source request, level or pulse.
- flush_pc  in  NUM_SRC*ADDR_W  redirect address per source; slice i is bits [i*ADDR_W +: ADDR_W], sampled with flush_req[i].
- flush_ack  in  1  downstream drain complete.
- flush_grant  out  NUM_SRC  one-hot, one-cycle pulse naming the winning source.
- flush_stage  out  NUM_STG  per-stage flush pulse.
- stall_fetch  out  1  high while a flush is in progress.
- redirect_valid  out  1  one-cycle redirect pulse.
- redirect_pc  out  ADDR_W  address held for the redirect.
- busy  out  1  high whenever the state is not IDLE.
- ack_timeout_err  out  1  sticky; set when WAIT_ACK times out.

## Operation
- Pending register (NUM_SRC bits):
  - Bit i is set on any edge where flush_req[i]=1.
  - Bit i is cleared only on the edge that grants source i.
  - If set and clear hit the same bit on the same edge, set wins.
- A PC holding register per source captures flush_pc[i] on every edge where flush_req[i]=1. A later request from the same source overwrites the earlier address.
- States and transitions:
  - IDLE: if pending is nonzero, grant the lowest set index w, latch redirect_pc from source w's PC register, load stage counter 0, go to FLUSH.
  - FLUSH: assert flush_stage[cnt] for one cycle and increment cnt. When cnt = NUM_STG-1, go to WAIT_ACK.
  - WAIT_ACK: on flush_ack=1, go to REDIRECT. If ACK_TIMEOUT cycles pass in this state without flush_ack, set ack_timeout_err and go to REDIRECT.
  - REDIRECT: assert redirect_valid for one cycle, then go to IDLE.
- Requests arriving while busy:
  - They are only accumulated in pending.
  - A flush in progress is never preempted.
  - After REDIRECT the block returns to IDLE, which re-arbitrates on the next cycle.
- flush_ack seen outside WAIT_ACK is ignored.
- ack_timeout_err clears only on reset.
- Reset:
  - All outputs 0, redirect_pc 0, pending 0, state IDLE.
  - Reset asserted mid-flush aborts the sequence with no redirect, and all pending requests are lost.

## Timing
- All outputs are registered.
- Reference cycle: E0 is the edge that samples flush_req[w]=1 in IDLE with an empty pending register.
- flush_grant[w] is high in the cycle after E1; redirect_pc is valid from the same cycle.
- flush_stage[i] is high in the cycle after edge E1+1+i, exactly one cycle wide, and never overlaps another stage bit.
- WAIT_ACK is entered after the last stage pulse. If flush_ack is already high on that first WAIT_ACK cycle, redirect_valid is high in the following cycle.
- Best-case request-to-redirect latency is NUM_STG+3 cycles (8 with the default NUM_STG=5).
- stall_fetch and busy:
  - Both rise with flush_grant.
  - stall_fetch falls after the redirect_valid cycle.
  - busy is low for at least one cycle between back-to-back flushes.
- Timeout: if flush_ack never arrives, redirect_valid fires ACK_TIMEOUT+1 cycles after WAIT_ACK entry, in the same cycle that ack_timeout_err first reads 1.

## Test plan
- Single request: source 2 pulses for 1 cycle with pc 0x0000_1000, flush_ack tied high → grant=4'b0100; flush_stage walks 00001→10000 on consecutive cycles; redirect_valid 8 cycles after the request with redirect_pc 0x1000; stall_fetch spans grant through redirect.
- Simultaneous requests: sources 1 and 3 in the same cycle → source 1 is served first. Source 3 is served afterwards with its own pc, after one IDLE cycle.
- Request during flush: source 0 requests while source 2's flush is in progress → source 2's sequence completes unaltered, then source 0 is granted.
- Missing ack: flush_ack held 0 with ACK_TIMEOUT=15 → redirect_valid 16 cycles after WAIT_ACK entry, and ack_timeout_err stays 1 thereafter.
- Reset mid-flush: reset_n pulled low while flush_stage=00100 → all outputs go to 0 immediately (asynchronously); no redirect follows; a request after reset_n rises starts a clean sequence.
